fastica_seq_ctrl: RTL and testbench

Parametrised top-level sequencer for the FastICA datapath. It runs whitening, streams the whitened samples into mem1 with a counted write burst, then runs FastICA once per independent component, pulsing new_one between components. Over the previous controller it adds configurable burst length and component count, an explicit done/error status, busy-wait timeouts, abort, and a driven mem1 address. It sits directly under the processor top and drives the whitening, mem1 and fastica enables.

---
 rtl/fastica_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_fastica_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fastica_seq_ctrl.sv
// Top-level FastICA sequencer: whitening, counted mem1 write burst, then one
// FastICA pass per component with new_one pulses, done/error status and abort.
module fastica_seq_ctrl #(
  parameter int ADDR_W   = 14,
  parameter int XFER_LEN = 126,
  parameter int N_COMP   = 2,
  parameter int TO_W     = 16,
  parameter int TO_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              whitening_busy,
  input  logic              fastica_busy,
  output logic              go_whitening,
  output logic              go_ram1,
  output logic              go_fastica,
  output logic              rw,
  output logic              new_one,
  output logic [ADDR_W-1:0] address_sel_mem1,
  output logic [7:0]        comp_idx,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int XC_W = $clog2(XFER_LEN + 1);
  localparam logic [XC_W-1:0] XFER_LAST = XC_W'(XFER_LEN - 1);
  localparam logic [7:0]      COMP_LAST = 8'(N_COMP - 1);
  // Trip one count early so the timer reaches 2^TO_W-1 on the aborting edge.
  localparam logic [TO_W-1:0] TO_TRIP   = ~TO_W'(1);

  typedef enum logic [2:0] {
    IDLE, WH_GO, WH_WAIT, XFER, TAIL, FI_WAIT, NEXT, DONE
  } state_t;

  state_t            state_reg, state_next;
  logic              guard_reg, guard_next;
  logic [XC_W-1:0]   xfer_cnt_reg, xfer_cnt_next;
  logic [TO_W-1:0]   timer_reg, timer_next;
  logic [7:0]        comp_next;
  logic              error_next;
  logic              go_whitening_next, go_ram1_next, go_fastica_next, rw_next;
  logic              new_one_next, busy_next, done_next;
  logic [ADDR_W-1:0] addr_next;

  always_comb begin
    state_next    = state_reg;
    guard_next    = guard_reg;
    xfer_cnt_next = xfer_cnt_reg;
    timer_next    = timer_reg;
    comp_next     = comp_idx;
    error_next    = error;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = WH_GO;
          error_next = 1'b0;
        end
      end
      WH_GO: begin
        if (guard_reg) begin
          state_next = WH_WAIT;
          timer_next = '0;
        end else begin
          guard_next = 1'b1;
        end
      end
      WH_WAIT: begin
        if (!whitening_busy) begin
          state_next    = XFER;
          xfer_cnt_next = '0;
        end else if ((TO_EN != 0) && (timer_reg == TO_TRIP)) begin
          state_next = IDLE;
          error_next = 1'b1;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      XFER: begin
        if (xfer_cnt_reg == XFER_LAST) state_next = TAIL;
        else xfer_cnt_next = xfer_cnt_reg + 1'b1;
      end
      TAIL: begin
        state_next = FI_WAIT;
        timer_next = '0;
      end
      FI_WAIT: begin
        if (!fastica_busy) begin
          if (comp_idx == COMP_LAST) begin
            state_next = DONE;
          end else begin
            state_next = NEXT;
            comp_next  = comp_idx + 8'd1;
          end
        end else if ((TO_EN != 0) && (timer_reg == TO_TRIP)) begin
          state_next = IDLE;
          error_next = 1'b1;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      NEXT: begin
        state_next = FI_WAIT;
        timer_next = '0;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Abort wins over everything, including a start or a timeout this cycle.
    if (abort) begin
      state_next = IDLE;
      error_next = error;
    end

    if (state_next == IDLE) begin
      guard_next    = 1'b0;
      xfer_cnt_next = '0;
      timer_next    = '0;
      comp_next     = '0;
    end

    go_whitening_next = (state_next == WH_GO) || (state_next == WH_WAIT) ||
                        (state_next == XFER);
    go_ram1_next      = (state_next == XFER) || (state_next == TAIL);
    go_fastica_next   = (state_next == XFER) || (state_next == TAIL) ||
                        (state_next == FI_WAIT) || (state_next == NEXT);
    rw_next           = go_ram1_next;
    new_one_next      = (state_next == NEXT);
    done_next         = (state_next == DONE);
    busy_next         = (state_next != IDLE);
    addr_next         = (state_next == XFER) ? ADDR_W'(xfer_cnt_next) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      guard_reg        <= 1'b0;
      xfer_cnt_reg     <= '0;
      timer_reg        <= '0;
      go_whitening     <= 1'b0;
      go_ram1          <= 1'b0;
      go_fastica       <= 1'b0;
      rw               <= 1'b0;
      new_one          <= 1'b0;
      address_sel_mem1 <= '0;
      comp_idx         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      state_reg        <= state_next;
      guard_reg        <= guard_next;
      xfer_cnt_reg     <= xfer_cnt_next;
      timer_reg        <= timer_next;
      go_whitening     <= go_whitening_next;
      go_ram1          <= go_ram1_next;
      go_fastica       <= go_fastica_next;
      rw               <= rw_next;
      new_one          <= new_one_next;
      address_sel_mem1 <= addr_next;
      comp_idx         <= comp_next;
      busy             <= busy_next;
      done             <= done_next;
      error            <= error_next;
    end
  end

endmodule

// File: tb/tb_fastica_seq_ctrl.sv
// Bench for fastica_seq_ctrl: a default instance driven from a scenario table
// with a run scoreboard, and a small instance for timeout and multi-component runs.
module tb_fastica_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instance A: default parameters ----------------
  logic        a_start, a_abort, a_wb, a_fb;
  logic        a_gw, a_gr, a_gf, a_rw, a_new, a_busy, a_done, a_err;
  logic [13:0] a_addr;
  logic [7:0]  a_comp;

  fastica_seq_ctrl u_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
    .whitening_busy(a_wb), .fastica_busy(a_fb),
    .go_whitening(a_gw), .go_ram1(a_gr), .go_fastica(a_gf), .rw(a_rw),
    .new_one(a_new), .address_sel_mem1(a_addr), .comp_idx(a_comp),
    .busy(a_busy), .done(a_done), .error(a_err)
  );

  // ---------------- instance B: short burst, 3 components, 4-bit timer ----------------
  logic        b_start, b_abort, b_wb, b_fb;
  logic        b_gw, b_gr, b_gf, b_rw, b_new, b_busy, b_done, b_err;
  logic [13:0] b_addr;
  logic [7:0]  b_comp;

  fastica_seq_ctrl #(.ADDR_W(14), .XFER_LEN(4), .N_COMP(3), .TO_W(4), .TO_EN(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .whitening_busy(b_wb), .fastica_busy(b_fb),
    .go_whitening(b_gw), .go_ram1(b_gr), .go_fastica(b_gf), .rw(b_rw),
    .new_one(b_new), .address_sel_mem1(b_addr), .comp_idx(b_comp),
    .busy(b_busy), .done(b_done), .error(b_err)
  );

  // FastICA unit stand-ins: busy for fi_len cycles after TAIL or new_one.
  int a_fi_len = 5, a_fb_cnt = 0;
  int b_fi_len = 5, b_fb_cnt = 0;
  always @(posedge clk) begin
    if ((a_gr && !a_gw) || a_new) a_fb_cnt <= a_fi_len;
    else if (a_fb_cnt != 0)       a_fb_cnt <= a_fb_cnt - 1;
    if ((b_gr && !b_gw) || b_new) b_fb_cnt <= b_fi_len;
    else if (b_fb_cnt != 0)       b_fb_cnt <= b_fb_cnt - 1;
  end
  assign a_fb = (a_fb_cnt != 0);
  assign b_fb = (b_fb_cnt != 0);

  // Scenario record: stimulus followed by the expected run summary.
  typedef struct {
    int wb_lo; int wb_hi; int fi_len; int abort_at;
    int x_first; int x_cycles; int n_new; int n_done; int last_comp;
  } vec_t;

  vec_t sb_a[$];
  vec_t obs_a;
  vec_t a_exp;
  vec_t tbl[5];
  int   a_start_cyc = 0;
  bit   mon_a_en = 1'b0;
  logic a_busy_q = 1'b0, a_done_q = 1'b0;

  always @(negedge clk) begin
    if (mon_a_en) begin
      if (a_busy) begin
        if (a_gw && a_gr) begin
          if (obs_a.x_cycles == 0) begin
            obs_a.x_first = cyc - a_start_cyc;
            check("a_comp_at_xfer", a_comp, 0);
          end
          check("a_xfer_addr", a_addr, obs_a.x_cycles);
          check("a_xfer_rw", a_rw, 1);
          obs_a.x_cycles++;
        end
        if (a_new) obs_a.n_new++;
        if (a_done) obs_a.n_done++;
        if (a_comp > obs_a.last_comp) obs_a.last_comp = a_comp;
      end
      if (a_done_q) check("a_busy_after_done", a_busy, 0);
      if (a_busy_q && !a_busy) begin
        check("a_idle_enables", {a_gw, a_gr, a_gf, a_rw, a_new, a_done}, 0);
        check("a_error_end", a_err, 0);
        if (sb_a.size() == 0) begin
          check("a_run_unexpected", a_busy_q, 0);
        end else begin
          a_exp = sb_a.pop_front();
          $display("run: xfer_first=%0d xfer=%0d new_one=%0d done=%0d comp=%0d",
                   obs_a.x_first, obs_a.x_cycles, obs_a.n_new, obs_a.n_done, obs_a.last_comp);
          check("a_xfer_first", obs_a.x_first, a_exp.x_first);
          check("a_xfer_cycles", obs_a.x_cycles, a_exp.x_cycles);
          check("a_new_one_count", obs_a.n_new, a_exp.n_new);
          check("a_done_count", obs_a.n_done, a_exp.n_done);
          check("a_last_comp", obs_a.last_comp, a_exp.last_comp);
        end
        obs_a = '{default: 0};
      end
    end
    a_busy_q = a_busy;
    a_done_q = a_done;
  end

  // Instance B event scoreboard: new_one/done pulses with the comp_idx they carry.
  typedef struct { bit is_done; int comp; } ev_t;
  ev_t sb_b[$];
  ev_t b_ev;
  int  b_xfer = 0;

  always @(negedge clk) begin
    if (b_gw && b_gr) begin
      check("b_xfer_addr", b_addr, b_xfer);
      b_xfer++;
    end
    if (b_new || b_done) begin
      if (sb_b.size() == 0) begin
        check("b_unexpected_event", {b_new, b_done}, 0);
      end else begin
        b_ev = sb_b.pop_front();
        $display("event: done=%0b new_one=%0b comp_idx=%0d", b_done, b_new, b_comp);
        check("b_event_kind", b_done, b_ev.is_done);
        check("b_event_comp", b_comp, b_ev.comp);
      end
    end
  end

  task automatic run_a(input vec_t v);
    bit seen, fin;
    @(posedge clk); #1;
    a_fi_len    = v.fi_len;
    obs_a       = '{default: 0};
    sb_a.push_back(v);
    a_start_cyc = cyc;
    a_start     = 1'b1;
    seen = 1'b0;
    fin  = 1'b0;
    for (int rel = 0; rel < 3000 && !fin; rel++) begin
      a_wb    = (rel >= v.wb_lo) && (rel <= v.wb_hi);
      a_abort = (v.abort_at >= 0) && a_gw && a_gr && (a_addr == 14'(v.abort_at));
      @(posedge clk); #1;
      a_start = 1'b0;
      a_abort = 1'b0;
      if (a_busy) seen = 1'b1;
      else if (seen) fin = 1'b1;
    end
    a_wb = 1'b0;
    check("a_run_finished", fin, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fin, found;
    int cnt_new, cnt_done, cnt_busy;

    rst = 1'b1;
    a_start = 1'b0; a_abort = 1'b0; a_wb = 1'b0;
    b_start = 1'b0; b_abort = 1'b0; b_wb = 1'b0;

    tbl[0] = '{3, 10, 5, -1, 12, 126, 1, 1, 1};  // defaults run
    tbl[1] = '{1,  0, 5, -1,  4, 126, 1, 1, 1};  // whitening already idle
    tbl[2] = '{3,  5, 5, 40,  7,  41, 0, 0, 0};  // abort at address 40
    tbl[3] = '{1,  0, 0, -1,  4, 126, 1, 1, 1};  // restart, fastica never busy
    tbl[4] = '{3,  3, 1, -1,  5, 126, 1, 1, 1};  // one busy cycle each side

    repeat (3) @(posedge clk);
    #1;
    check("rst_a_outputs", {a_gw, a_gr, a_gf, a_rw, a_new, a_busy, a_done, a_err, a_addr, a_comp}, 0);
    check("rst_b_outputs", {b_gw, b_gr, b_gf, b_rw, b_new, b_busy, b_done, b_err, b_addr, b_comp}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("a_idle_after_release", {a_gw, a_gr, a_gf, a_rw, a_busy, a_err}, 0);

    // abort in IDLE masks a simultaneous start
    a_start = 1'b1; a_abort = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0; a_abort = 1'b0;
    check("a_abort_blocks_start", a_busy, 0);

    mon_a_en = 1'b1;
    foreach (tbl[i]) run_a(tbl[i]);
    @(negedge clk);
    @(posedge clk); #1;
    check("a_scoreboard_drained", sb_a.size(), 0);
    mon_a_en = 1'b0;

    // B: whitening stuck busy -> timeout 15 cycles after WH_WAIT entry
    @(posedge clk); #1;
    b_start = 1'b1; b_wb = 1'b1;
    for (int rel = 1; rel <= 18; rel++) begin
      @(posedge clk); #1;
      b_start = 1'b0;
      if (rel == 17) begin
        check("b_busy_before_timeout", b_busy, 1);
        check("b_error_before_timeout", b_err, 0);
      end
      if (rel == 18) begin
        check("b_busy_after_timeout", b_busy, 0);
        check("b_error_after_timeout", b_err, 1);
        check("b_enables_after_timeout", {b_gw, b_gr, b_gf, b_done}, 0);
      end
    end
    b_wb = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("b_error_sticky", b_err, 1);

    // B: restart clears error; 4-sample burst, three components
    sb_b.push_back('{1'b0, 1});
    sb_b.push_back('{1'b0, 2});
    sb_b.push_back('{1'b1, 2});
    b_xfer  = 0;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    check("b_error_cleared", b_err, 0);
    check("b_busy_restart", b_busy, 1);
    fin = 1'b0;
    for (int i = 0; i < 500 && !fin; i++) begin
      @(posedge clk); #1;
      if (!b_busy) fin = 1'b1;
    end
    check("b_run_finished", fin, 1);
    @(negedge clk);
    check("b_xfer_count", b_xfer, 4);
    check("b_events_left", sb_b.size(), 0);

    // A: asynchronous reset while waiting in FI_WAIT
    @(posedge clk); #1;
    a_fi_len = 40;
    a_start  = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (a_busy && a_gf && !a_gr && !a_new) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("a_reach_fi_wait", found, 1);
    #2 rst = 1'b1;
    #1;
    check("a_async_rst_outputs", {a_gw, a_gr, a_gf, a_rw, a_new, a_busy, a_done, a_err}, 0);
    check("a_async_rst_addr_comp", {a_addr, a_comp}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt_new = 0; cnt_done = 0; cnt_busy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (a_new)  cnt_new++;
      if (a_done) cnt_done++;
      if (a_busy) cnt_busy++;
    end
    check("a_no_new_one_after_rst", cnt_new, 0);
    check("a_no_done_after_rst", cnt_done, 0);
    check("a_no_busy_after_rst", cnt_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
